// File: rtl/pipe_pkg.sv
// pipe_pkg: encodings and bundle types shared by the pipelined RV32 core.
//   wdsel_e     - write-back source select (ALU / memory / PC+4)
//   npcop_e     - next-PC operation
//   EXT_*       - bit positions inside the one-hot EXTOp decoder field
//   ctrl_t      - decoded control bundle carried down the pipeline
//   ex_bundle_t - complete contents of the ID/EX pipeline register
package pipe_pkg;

    typedef enum logic [1:0] {
        WD_FROM_ALU = 2'b00,
        WD_FROM_MEM = 2'b01,
        WD_FROM_PC  = 2'b10
    } wdsel_e;

    typedef enum logic [2:0] {
        NPC_PLUS4  = 3'b000,
        NPC_BRANCH = 3'b001,
        NPC_JUMP   = 3'b010,
        NPC_JALR   = 3'b100
    } npcop_e;

    localparam int unsigned EXT_SHAMT = 5;
    localparam int unsigned EXT_I     = 4;
    localparam int unsigned EXT_S     = 3;
    localparam int unsigned EXT_B     = 2;
    localparam int unsigned EXT_U     = 1;
    localparam int unsigned EXT_J     = 0;

    typedef struct packed {
        logic       reg_write;
        logic       mem_write;
        logic       alu_src;
        logic [5:0] ext_op;
        logic [4:0] alu_op;
        logic [2:0] npc_op;
        logic [2:0] dm_type;
        logic [1:0] wd_sel;
    } ctrl_t;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [31:0] rd1;
        logic [31:0] rd2;
        logic [31:0] imm;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        ctrl_t       ctrl;
    } ex_bundle_t;

endpackage

// File: rtl/load_use_detect.sv
// load_use_detect: combinational load-use hazard detection.
//   ex_valid, ex_wd_sel, ex_rd   - instruction currently in EX
//   id_valid, id_rs1, id_rs2     - instruction currently in ID
//   id_ext_uj                    - EXTOp bits {U, J}; those types do not read rs1
//   id_alu_src, id_mem_write     - decide whether ID reads rs2 (R, B, S types)
//   load_use                     - EX load writes a register ID is about to read
module load_use_detect
    import pipe_pkg::*;
(
    input  logic       ex_valid,
    input  logic [1:0] ex_wd_sel,
    input  logic [4:0] ex_rd,
    input  logic       id_valid,
    input  logic [4:0] id_rs1,
    input  logic [4:0] id_rs2,
    input  logic [1:0] id_ext_uj,
    input  logic       id_alu_src,
    input  logic       id_mem_write,
    output logic       load_use
);

    logic uses_rs1;
    logic uses_rs2;
    logic ex_is_load;

    always_comb begin
        uses_rs1   = ~(id_ext_uj[1] | id_ext_uj[0]);
        uses_rs2   = ~id_alu_src | id_mem_write;
        // x0 is never a real destination, so a load into x0 cannot create a hazard
        ex_is_load = ex_valid & (ex_wd_sel == WD_FROM_MEM) & (ex_rd != 5'd0);
        load_use   = ex_is_load & id_valid &
                     ((uses_rs1 & (ex_rd == id_rs1)) | (uses_rs2 & (ex_rd == id_rs2)));
    end

endmodule

// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register of the RV32 core.
//   clk, rstn            - clock, asynchronous active-low reset
//   id_*                 - decoded instruction from the decode stage
//   flush_i              - squash the instruction entering EX (load a bubble)
//   hold_i               - back-end stall, freeze the EX register
//   stall_o              - combinational load-use stall request to PC and IF/ID
//   ex_*                 - registered instruction for the execute stage
//   bubble_cnt/flush_cnt - saturating counts of load-use bubbles and flushes
// Update priority: flush > hold > load-use bubble > normal load.
module id_ex_stage
    import pipe_pkg::*;
#(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             id_valid,
    input  logic [31:0]      id_pc,
    input  logic [31:0]      id_rd1,
    input  logic [31:0]      id_rd2,
    input  logic [31:0]      id_imm,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic [4:0]       id_rd,
    input  logic             id_RegWrite,
    input  logic             id_MemWrite,
    input  logic             id_ALUSrc,
    input  logic [5:0]       id_EXTOp,
    input  logic [4:0]       id_ALUOp,
    input  logic [2:0]       id_NPCOp,
    input  logic [2:0]       id_DMType,
    input  logic [1:0]       id_WDSel,
    input  logic             flush_i,
    input  logic             hold_i,
    output logic             stall_o,
    output logic             ex_valid,
    output logic [31:0]      ex_pc,
    output logic [31:0]      ex_rd1,
    output logic [31:0]      ex_rd2,
    output logic [31:0]      ex_imm,
    output logic [4:0]       ex_rs1,
    output logic [4:0]       ex_rs2,
    output logic [4:0]       ex_rd,
    output logic             ex_RegWrite,
    output logic             ex_MemWrite,
    output logic             ex_ALUSrc,
    output logic [5:0]       ex_EXTOp,
    output logic [4:0]       ex_ALUOp,
    output logic [2:0]       ex_NPCOp,
    output logic [2:0]       ex_DMType,
    output logic [1:0]       ex_WDSel,
    output logic [CNT_W-1:0] bubble_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    ex_bundle_t ex_q;
    ex_bundle_t ex_d;
    logic       load_use;

    load_use_detect u_load_use_detect (
        .ex_valid     (ex_q.valid),
        .ex_wd_sel    (ex_q.ctrl.wd_sel),
        .ex_rd        (ex_q.rd),
        .id_valid     (id_valid),
        .id_rs1       (id_rs1),
        .id_rs2       (id_rs2),
        .id_ext_uj    ({id_EXTOp[EXT_U], id_EXTOp[EXT_J]}),
        .id_alu_src   (id_ALUSrc),
        .id_mem_write (id_MemWrite),
        .load_use     (load_use)
    );

    // A flush or hold overrides the hazard, so no stall is requested then
    assign stall_o = load_use & ~flush_i & ~hold_i;

    always_comb begin
        ex_d = ex_q;
        if (flush_i) begin
            ex_d = '0;
        end else if (hold_i) begin
            ex_d = ex_q;
        end else if (load_use) begin
            ex_d = '0;
        end else begin
            ex_d.valid          = id_valid;
            ex_d.pc             = id_pc;
            ex_d.rd1            = id_rd1;
            ex_d.rd2            = id_rd2;
            ex_d.imm            = id_imm;
            ex_d.rs1            = id_rs1;
            ex_d.rs2            = id_rs2;
            ex_d.rd             = id_rd;
            ex_d.ctrl.reg_write = id_RegWrite;
            ex_d.ctrl.mem_write = id_MemWrite;
            ex_d.ctrl.alu_src   = id_ALUSrc;
            ex_d.ctrl.ext_op    = id_EXTOp;
            ex_d.ctrl.alu_op    = id_ALUOp;
            ex_d.ctrl.npc_op    = id_NPCOp;
            ex_d.ctrl.dm_type   = id_DMType;
            ex_d.ctrl.wd_sel    = id_WDSel;
            // an empty decode slot must not change architectural state
            if (!id_valid) begin
                ex_d.ctrl.reg_write = 1'b0;
                ex_d.ctrl.mem_write = 1'b0;
                ex_d.ctrl.npc_op    = NPC_PLUS4;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ex_q <= '0;
        end else begin
            ex_q <= ex_d;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            bubble_cnt <= '0;
            flush_cnt  <= '0;
        end else begin
            if (flush_i && (flush_cnt != '1)) begin
                flush_cnt <= flush_cnt + 1'b1;
            end
            if (stall_o && (bubble_cnt != '1)) begin
                bubble_cnt <= bubble_cnt + 1'b1;
            end
        end
    end

    assign ex_valid    = ex_q.valid;
    assign ex_pc       = ex_q.pc;
    assign ex_rd1      = ex_q.rd1;
    assign ex_rd2      = ex_q.rd2;
    assign ex_imm      = ex_q.imm;
    assign ex_rs1      = ex_q.rs1;
    assign ex_rs2      = ex_q.rs2;
    assign ex_rd       = ex_q.rd;
    assign ex_RegWrite = ex_q.ctrl.reg_write;
    assign ex_MemWrite = ex_q.ctrl.mem_write;
    assign ex_ALUSrc   = ex_q.ctrl.alu_src;
    assign ex_EXTOp    = ex_q.ctrl.ext_op;
    assign ex_ALUOp    = ex_q.ctrl.alu_op;
    assign ex_NPCOp    = ex_q.ctrl.npc_op;
    assign ex_DMType   = ex_q.ctrl.dm_type;
    assign ex_WDSel    = ex_q.ctrl.wd_sel;

endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: directed test of id_ex_stage (default CNT_W plus a CNT_W=4
// instance driven by the same inputs to exercise counter saturation).
module tb_id_ex_stage;

    logic        clk;
    logic        rstn;
    logic        id_valid;
    logic [31:0] id_pc, id_rd1, id_rd2, id_imm;
    logic [4:0]  id_rs1, id_rs2, id_rd;
    logic        id_RegWrite, id_MemWrite, id_ALUSrc;
    logic [5:0]  id_EXTOp;
    logic [4:0]  id_ALUOp;
    logic [2:0]  id_NPCOp, id_DMType;
    logic [1:0]  id_WDSel;
    logic        flush_i, hold_i;

    logic        stall_o, ex_valid;
    logic [31:0] ex_pc, ex_rd1, ex_rd2, ex_imm;
    logic [4:0]  ex_rs1, ex_rs2, ex_rd;
    logic        ex_RegWrite, ex_MemWrite, ex_ALUSrc;
    logic [5:0]  ex_EXTOp;
    logic [4:0]  ex_ALUOp;
    logic [2:0]  ex_NPCOp, ex_DMType;
    logic [1:0]  ex_WDSel;
    logic [15:0] bubble_cnt, flush_cnt;

    logic        s_stall_o, s_ex_valid;
    logic [31:0] s_ex_pc, s_ex_rd1, s_ex_rd2, s_ex_imm;
    logic [4:0]  s_ex_rs1, s_ex_rs2, s_ex_rd;
    logic        s_ex_RegWrite, s_ex_MemWrite, s_ex_ALUSrc;
    logic [5:0]  s_ex_EXTOp;
    logic [4:0]  s_ex_ALUOp;
    logic [2:0]  s_ex_NPCOp, s_ex_DMType;
    logic [1:0]  s_ex_WDSel;
    logic [3:0]  s_bubble_cnt, s_flush_cnt;

    int unsigned checks = 0;
    int unsigned errors = 0;

    id_ex_stage u_dut (
        .clk(clk), .rstn(rstn), .id_valid(id_valid), .id_pc(id_pc),
        .id_rd1(id_rd1), .id_rd2(id_rd2), .id_imm(id_imm),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
        .id_RegWrite(id_RegWrite), .id_MemWrite(id_MemWrite), .id_ALUSrc(id_ALUSrc),
        .id_EXTOp(id_EXTOp), .id_ALUOp(id_ALUOp), .id_NPCOp(id_NPCOp),
        .id_DMType(id_DMType), .id_WDSel(id_WDSel),
        .flush_i(flush_i), .hold_i(hold_i), .stall_o(stall_o),
        .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_rd1(ex_rd1), .ex_rd2(ex_rd2),
        .ex_imm(ex_imm), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
        .ex_RegWrite(ex_RegWrite), .ex_MemWrite(ex_MemWrite), .ex_ALUSrc(ex_ALUSrc),
        .ex_EXTOp(ex_EXTOp), .ex_ALUOp(ex_ALUOp), .ex_NPCOp(ex_NPCOp),
        .ex_DMType(ex_DMType), .ex_WDSel(ex_WDSel),
        .bubble_cnt(bubble_cnt), .flush_cnt(flush_cnt)
    );

    id_ex_stage #(.CNT_W(4)) u_sat (
        .clk(clk), .rstn(rstn), .id_valid(id_valid), .id_pc(id_pc),
        .id_rd1(id_rd1), .id_rd2(id_rd2), .id_imm(id_imm),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
        .id_RegWrite(id_RegWrite), .id_MemWrite(id_MemWrite), .id_ALUSrc(id_ALUSrc),
        .id_EXTOp(id_EXTOp), .id_ALUOp(id_ALUOp), .id_NPCOp(id_NPCOp),
        .id_DMType(id_DMType), .id_WDSel(id_WDSel),
        .flush_i(flush_i), .hold_i(hold_i), .stall_o(s_stall_o),
        .ex_valid(s_ex_valid), .ex_pc(s_ex_pc), .ex_rd1(s_ex_rd1), .ex_rd2(s_ex_rd2),
        .ex_imm(s_ex_imm), .ex_rs1(s_ex_rs1), .ex_rs2(s_ex_rs2), .ex_rd(s_ex_rd),
        .ex_RegWrite(s_ex_RegWrite), .ex_MemWrite(s_ex_MemWrite), .ex_ALUSrc(s_ex_ALUSrc),
        .ex_EXTOp(s_ex_EXTOp), .ex_ALUOp(s_ex_ALUOp), .ex_NPCOp(s_ex_NPCOp),
        .ex_DMType(s_ex_DMType), .ex_WDSel(s_ex_WDSel),
        .bubble_cnt(s_bubble_cnt), .flush_cnt(s_flush_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Generic decode-slot driver; RegWrite is set for everything except stores
    task automatic set_id(input logic [31:0] pc, input logic [4:0] rs1, input logic [4:0] rs2,
                          input logic [4:0] rd, input logic [31:0] imm, input logic [5:0] ext,
                          input logic alusrc, input logic memwrite, input logic [1:0] wdsel);
        id_valid    = 1'b1;
        id_pc       = pc;
        id_rs1      = rs1;
        id_rs2      = rs2;
        id_rd       = rd;
        id_imm      = imm;
        id_rd1      = 32'hA000_0000 | {27'd0, rs1};
        id_rd2      = 32'hB000_0000 | {27'd0, rs2};
        id_EXTOp    = ext;
        id_ALUSrc   = alusrc;
        id_MemWrite = memwrite;
        id_RegWrite = ~memwrite;
        id_WDSel    = wdsel;
        id_ALUOp    = 5'd0;
        id_NPCOp    = 3'd0;
        id_DMType   = (memwrite || wdsel == 2'b01) ? 3'd2 : 3'd0;
    endtask

    task automatic set_addi(input logic [31:0] pc, input logic [4:0] rd, input logic [4:0] rs1,
                            input logic [31:0] imm);
        set_id(pc, rs1, 5'd0, rd, imm, 6'b010000, 1'b1, 1'b0, 2'b00);
    endtask

    task automatic set_lw(input logic [31:0] pc, input logic [4:0] rd, input logic [4:0] rs1);
        set_id(pc, rs1, 5'd0, rd, 32'd0, 6'b010000, 1'b1, 1'b0, 2'b01);
    endtask

    task automatic set_add(input logic [31:0] pc, input logic [4:0] rd, input logic [4:0] rs1,
                           input logic [4:0] rs2);
        set_id(pc, rs1, rs2, rd, 32'd0, 6'b000000, 1'b0, 1'b0, 2'b00);
    endtask

    initial begin
        rstn    = 1'b0;
        flush_i = 1'b0;
        hold_i  = 1'b0;
        set_addi(32'h0, 5'd0, 5'd0, 32'd0);
        id_valid = 1'b0;
        #3;
        check("rst_ex_valid", {31'd0, ex_valid}, 32'd0);
        check("rst_ex_pc", ex_pc, 32'd0);
        check("rst_bubble", {16'd0, bubble_cnt}, 32'd0);
        check("rst_flush", {16'd0, flush_cnt}, 32'd0);
        check("rst_stall", {31'd0, stall_o}, 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rstn = 1'b1;

        // straight flow: addi x1,x0,5
        set_addi(32'h100, 5'd1, 5'd0, 32'd5);
        #1 check("flow_stall", {31'd0, stall_o}, 32'd0);
        step();
        check("flow_valid", {31'd0, ex_valid}, 32'd1);
        check("flow_imm", ex_imm, 32'd5);
        check("flow_rd", {27'd0, ex_rd}, 32'd1);
        check("flow_regwrite", {31'd0, ex_RegWrite}, 32'd1);
        check("flow_pc", ex_pc, 32'h100);
        check("flow_extop", {26'd0, ex_EXTOp}, 32'h10);

        // load-use: lw x5 in EX, add x6,x5,x7 in ID
        set_lw(32'h104, 5'd5, 5'd1);
        step();
        check("lu_ex_wdsel", {30'd0, ex_WDSel}, 32'd1);
        set_add(32'h108, 5'd6, 5'd5, 5'd7);
        #1 check("lu_stall", {31'd0, stall_o}, 32'd1);
        step();
        check("lu_bub_valid", {31'd0, ex_valid}, 32'd0);
        check("lu_bub_regwrite", {31'd0, ex_RegWrite}, 32'd0);
        check("lu_bub_pc", ex_pc, 32'd0);
        check("lu_bubble_cnt", {16'd0, bubble_cnt}, 32'd1);
        check("lu_stall_clear", {31'd0, stall_o}, 32'd0);
        step();
        check("lu_add_valid", {31'd0, ex_valid}, 32'd1);
        check("lu_add_pc", ex_pc, 32'h108);
        check("lu_add_rd", {27'd0, ex_rd}, 32'd6);
        check("lu_add_rd1", ex_rd1, 32'hA000_0005);
        check("lu_bubble_hold", {16'd0, bubble_cnt}, 32'd1);

        // no false hazard A: lw x0 then use of x0
        set_lw(32'h10C, 5'd0, 5'd1);
        step();
        set_add(32'h110, 5'd6, 5'd0, 5'd0);
        #1 check("nfh_x0_stall", {31'd0, stall_o}, 32'd0);

        // no false hazard B: lw x5 then lui x5 (rs fields happen to be 5)
        set_lw(32'h114, 5'd5, 5'd1);
        step();
        set_id(32'h118, 5'd5, 5'd5, 5'd5, 32'h12345000, 6'b000010, 1'b1, 1'b0, 2'b00);
        #1 check("nfh_lui_stall", {31'd0, stall_o}, 32'd0);
        step();
        check("nfh_lui_pc", ex_pc, 32'h118);

        // rs2 hazard through a store: lw x5, sw x5,0(x2)
        set_lw(32'h11C, 5'd5, 5'd1);
        step();
        set_id(32'h120, 5'd2, 5'd5, 5'd0, 32'd0, 6'b001000, 1'b1, 1'b1, 2'b00);
        #1 check("sw_rs2_stall", {31'd0, stall_o}, 32'd1);
        step();
        check("sw_bubble_cnt", {16'd0, bubble_cnt}, 32'd2);
        check("sw_bub_memwrite", {31'd0, ex_MemWrite}, 32'd0);

        // flush wins over hold and load-use
        set_lw(32'h124, 5'd5, 5'd1);
        step();
        set_add(32'h128, 5'd6, 5'd5, 5'd7);
        flush_i = 1'b1;
        hold_i  = 1'b1;
        #1 check("fl_stall", {31'd0, stall_o}, 32'd0);
        step();
        flush_i = 1'b0;
        hold_i  = 1'b0;
        check("fl_valid", {31'd0, ex_valid}, 32'd0);
        check("fl_rd", {27'd0, ex_rd}, 32'd0);
        check("fl_flush_cnt", {16'd0, flush_cnt}, 32'd1);
        check("fl_bubble_cnt", {16'd0, bubble_cnt}, 32'd2);

        // hold for 3 cycles with changing ID contents, including a hazard
        set_lw(32'h200, 5'd5, 5'd1);
        step();
        hold_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            set_add(32'h300 + 32'(4 * i), 5'(6 + i), 5'd5, 5'd7);
            #1 check("hold_stall", {31'd0, stall_o}, 32'd0);
            step();
            check("hold_pc", ex_pc, 32'h200);
            check("hold_rd", {27'd0, ex_rd}, 32'd5);
        end
        set_addi(32'h210, 5'd9, 5'd2, 32'd7);
        hold_i = 1'b0;
        #1 check("rel_stall", {31'd0, stall_o}, 32'd0);
        step();
        check("rel_pc", ex_pc, 32'h210);
        check("rel_rd", {27'd0, ex_rd}, 32'd9);
        check("rel_imm", ex_imm, 32'd7);
        check("rel_bubble_cnt", {16'd0, bubble_cnt}, 32'd2);

        // empty decode slot: data captured, side effects suppressed
        set_addi(32'h214, 5'd3, 5'd0, 32'h55);
        id_valid = 1'b0;
        step();
        check("inv_valid", {31'd0, ex_valid}, 32'd0);
        check("inv_regwrite", {31'd0, ex_RegWrite}, 32'd0);
        check("inv_imm", ex_imm, 32'h55);

        // asynchronous reset mid-stream
        set_addi(32'h218, 5'd4, 5'd0, 32'h66);
        step();
        #2 rstn = 1'b0;
        #1;
        check("arst_valid", {31'd0, ex_valid}, 32'd0);
        check("arst_pc", ex_pc, 32'd0);
        check("arst_imm", ex_imm, 32'd0);
        check("arst_bubble", {16'd0, bubble_cnt}, 32'd0);
        check("arst_flush", {16'd0, flush_cnt}, 32'd0);
        @(negedge clk);
        rstn = 1'b1;

        // saturation: 20 flushes
        flush_i = 1'b1;
        repeat (20) step();
        flush_i = 1'b0;
        check("sat_flush_wide", {16'd0, flush_cnt}, 32'd20);
        check("sat_flush_narrow", {28'd0, s_flush_cnt}, 32'd15);
        check("sat_bubble_narrow", {28'd0, s_bubble_cnt}, 32'd0);
        step();
        check("sat_flush_stay", {28'd0, s_flush_cnt}, 32'd15);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

ID/EX pipeline stage of the pipelined RV32 core. It registers the decoded control bundle, operands, immediate and register indices from the decode stage into the execute stage. It detects load-use hazards and inserts one bubble for each. It also applies branch/jump flushes and back-end holds, and keeps saturating counts of inserted bubbles and flushes.

## Interface
Parameters:
- CNT_W, 16, width of the bubble and flush event counters.

Ports:
- clk  in  1  rising-edge clock
- rstn  in  1  asynchronous, active-low reset
- id_valid  in  1  decode slot holds a real instruction
- id_pc  in  32  PC of the decode instruction
- id_rd1, id_rd2  in  32 each  register-file read data
- id_imm  in  32  extended immediate
- id_rs1, id_rs2, id_rd  in  5 each  register indices
- id_RegWrite, id_MemWrite, id_ALUSrc  in  1 each  decoder control
- id_EXTOp  in  6  decoder control (one-hot: bit5 shamt, 4 I, 3 S, 2 B, 1 U, 0 J)
- id_ALUOp  in  5  decoder control
- id_NPCOp  in  3  decoder control
- id_DMType  in  3  decoder control
- id_WDSel  in  2  decoder control (01 = from memory, i.e. load)
- flush_i  in  1  redirect from branch resolution; squash the instruction entering EX
- hold_i  in  1  back-end stall; freeze the EX register
- stall_o  out  1  load-use stall request to PC and IF/ID (combinational)
- ex_valid  out  1  EX slot holds a real instruction
- ex_pc, ex_rd1, ex_rd2, ex_imm  out  32 each  registered copies
- ex_rs1, ex_rs2, ex_rd  out  5 each  registered copies
- ex_RegWrite, ex_MemWrite, ex_ALUSrc, ex_EXTOp, ex_ALUOp, ex_NPCOp, ex_DMType, ex_WDSel  out  widths as the id_ inputs  registered control
- bubble_cnt, flush_cnt  out  CNT_W each  saturating event counters

## Operation
- uses_rs1 = ~(id_EXTOp[1] | id_EXTOp[0]). U- and J-type instructions do not read rs1.
- uses_rs2 = ~id_ALUSrc | id_MemWrite. This covers R-, B- and S-type.
- load_use = ex_valid & (ex_WDSel==2'b01) & (ex_rd!=0) & id_valid & ((uses_rs1 & ex_rd==id_rs1) | (uses_rs2 & ex_rd==id_rs2)).
- stall_o = load_use & ~flush_i & ~hold_i.
- Register update priority, highest first:
  1. flush_i: load a bubble.
  2. hold_i: keep the current contents.
  3. load_use: load a bubble.
  4. Otherwise: load the id_ values, with ex_valid = id_valid.
- Bubble:
  - ex_valid = 0.
  - RegWrite, MemWrite and NPCOp are forced to 0.
  - All other fields are forced to 0 as well, for deterministic waveforms.
- An id_ instruction with id_valid = 0 is loaded with RegWrite, MemWrite and NPCOp forced to 0.
- bubble_cnt increments on every cycle where a load_use bubble is loaded (case 3).
- flush_cnt increments on every flush_i cycle.
- Both counters saturate at all-ones and never wrap.
- A load-use stall lasts exactly one cycle. After the bubble, EX no longer holds the load, so the hazard clears; the result is forwarded from MEM.

## Timing
- Reset (rstn low, asynchronous):
  - All ex_ outputs are 0; ex_valid = 0.
  - bubble_cnt = flush_cnt = 0.
  - stall_o = 0, because ex_valid = 0.
- Deassertion of rstn is sampled by the next rising clk edge. Reset mid-operation discards the EX contents and the counters.
- Latency: the id_ inputs appear on the ex_ outputs one clock after the edge at which they are sampled.
- stall_o is combinational in the same cycle as the hazard. Upstream must hold PC and IF/ID for that cycle.
- flush_i and load_use in the same cycle: a bubble is loaded, stall_o = 0, only flush_cnt increments.
- hold_i and load_use in the same cycle: the EX register holds, stall_o = 0. The hazard is re-evaluated after the hold is released. Upstream must already be frozen by hold_i.
- hold_i and flush_i in the same cycle: the flush wins.
- id_rd1/id_rd2 are captured as presented. Write-back bypass of the register file is outside this block.

## Structure
- Shared package pipe_pkg holds:
  - WDSel encodings (FROM_ALU 00, FROM_MEM 01, FROM_PC 10).
  - NPCOp encodings (PLUS4 000, BRANCH 001, JUMP 010, JALR 100).
  - EXTOp bit positions.
  - A packed control-bundle struct.
- One sub-module, load_use_detect, holds the combinational hazard equation (uses_rs1, uses_rs2, load_use).
- The pipeline register and the counters live in id_ex_stage.

## Test plan
- Straight flow:
  - Stimulus: addi x1,x0,5 (id_valid=1, id_imm=5, id_rd=1, EXTOp=010000, ALUSrc=1).
  - Response: next cycle ex_valid=1, ex_imm=5, ex_rd=1, ex_RegWrite=1; stall_o stays 0.
- Load-use:
  - Stimulus: EX holds lw x5 (WDSel=01, rd=5); ID presents add x6,x5,x7.
  - Response: stall_o=1 for one cycle; the next EX is a bubble (ex_valid=0, ex_RegWrite=0); bubble_cnt increments to 1; the following cycle the add enters EX.
- No false hazard:
  - Case A: lw x0 in EX followed by use of x0 in ID.
  - Case B: lw x5 in EX and lui x5 in ID (uses_rs1=0, uses_rs2=0).
  - Response: stall_o=0 in both cases.
- Flush priority:
  - Stimulus: flush_i=1 together with a load-use hazard and hold_i=1.
  - Response: bubble loaded; stall_o=0; flush_cnt increments; bubble_cnt unchanged.
- Hold:
  - Stimulus: hold_i=1 for 3 cycles with new id_ values each cycle.
  - Response: the ex_ outputs stay unchanged; on release, the current id_ values load.
- Reset and saturation:
  - Stimulus: assert rstn=0 mid-stream; separately, drive CNT_W=4 with 20 flushes.
  - Response: on reset, all outputs are 0 immediately (asynchronously); after 20 flushes, flush_cnt=15.
